led_sw_sequencer: RTL and testbench

- Avalon-MM slave on the HPS lightweight H2F bridge that owns the board LEDs and slide switches.
- Replaces the plain LED/SW PIOs: drives the LEDs from a hardware pattern sequencer (direct, blink, chase, switch-mirror) configured by software.
- Debounces the switches, latches switch changes and raises a maskable interrupt towards the HPS F2H IRQ lines.

---
 rtl/led_sw_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_led_sw_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sw_sequencer.sv
// LED pattern sequencer and debounced switch block behind an Avalon-MM slave.
// The LEDs are driven by a small run/idle FSM in one of four modes: direct, blink,
// chase or switch-mirror. The switches are synchronised and debounced. Each accepted
// switch change sets a sticky EDGE flag, and the flags drive a maskable level interrupt.
module led_sw_sequencer #(
    parameter int unsigned NUM_LEDS        = 8,
    parameter int unsigned NUM_SW          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    input  logic [NUM_SW-1:0]   sw_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                irq
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] AddrCtrl     = 3'd0;
    localparam logic [2:0] AddrPattern  = 3'd1;
    localparam logic [2:0] AddrPeriod   = 3'd2;
    localparam logic [2:0] AddrSwStatus = 3'd3;
    localparam logic [2:0] AddrIrqMask  = 3'd4;
    localparam logic [2:0] AddrEdge     = 3'd5;

    localparam logic [1:0] ModeDirect = 2'd0;
    localparam logic [1:0] ModeBlink  = 2'd1;
    localparam logic [1:0] ModeChase  = 2'd2;
    localparam logic [1:0] ModeMirror = 2'd3;

    typedef enum logic {StIdle, StRun} state_e;

    // Switch path
    logic [NUM_SW-1:0] sw_meta_q, sw_sync_q;
    logic [NUM_SW-1:0] sw_stable_q, sw_stable_d;
    logic [CntW-1:0]   db_cnt_q [NUM_SW];
    logic [CntW-1:0]   db_cnt_d [NUM_SW];
    logic [NUM_SW-1:0] edge_set;

    // Register file
    logic [3:0]          ctrl_q, ctrl_d;
    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    logic [31:0]         period_q, period_d;
    logic [NUM_SW-1:0]   irq_mask_q, irq_mask_d;
    logic [NUM_SW-1:0]   edge_q, edge_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                irq_q, irq_d;
    logic                wr_ctrl, wr_pattern, wr_period, wr_mask, wr_edge;

    // Sequencer
    state_e              state_q, state_d;
    logic [31:0]         step_q, step_d;
    logic [NUM_LEDS-1:0] shift_q, shift_d;
    logic                phase_q, phase_d;
    logic [1:0]          mode_q, eff_mode;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [NUM_LEDS-1:0] sw_led;
    logic                tick, restart;

    // Zero-extend or truncate the debounced switches onto the LED width.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_sw_led
        if (i < NUM_SW) begin : g_bit
            assign sw_led[i] = sw_stable_q[i];
        end else begin : g_zero
            assign sw_led[i] = 1'b0;
        end
    end

    assign wr_ctrl    = avs_write && (avs_address == AddrCtrl);
    assign wr_pattern = avs_write && (avs_address == AddrPattern);
    assign wr_period  = avs_write && (avs_address == AddrPeriod);
    assign wr_mask    = avs_write && (avs_address == AddrIrqMask);
    assign wr_edge    = avs_write && (avs_address == AddrEdge);

    assign eff_mode = ctrl_q[3] ? sw_stable_q[1:0] : ctrl_q[2:1];
    assign restart  = wr_pattern || wr_period || (eff_mode != mode_q);
    assign tick     = (step_q == period_q - 32'd1);

    // Per-bit debounce: accept a new level after DEBOUNCE_CYCLES consecutive disagreements.
    always_comb begin
        sw_stable_d = sw_stable_q;
        edge_set    = '0;
        db_cnt_d    = db_cnt_q;
        for (int i = 0; i < NUM_SW; i++) begin
            if (sw_sync_q[i] != sw_stable_q[i]) begin
                if (db_cnt_q[i] == CntMax) begin
                    sw_stable_d[i] = sw_sync_q[i];
                    db_cnt_d[i]    = '0;
                    edge_set[i]    = 1'b1;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CntW'(1);
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    // Register writes; a new edge wins over a simultaneous W1C of the same bit.
    always_comb begin
        ctrl_d     = wr_ctrl ? avs_writedata[3:0] : ctrl_q;
        pattern_d  = wr_pattern ? avs_writedata[NUM_LEDS-1:0] : pattern_q;
        period_d   = period_q;
        if (wr_period) begin
            period_d = (avs_writedata == 32'd0) ? 32'd1 : avs_writedata;
        end
        irq_mask_d = wr_mask ? avs_writedata[NUM_SW-1:0] : irq_mask_q;
        edge_d     = (edge_q & ~(wr_edge ? avs_writedata[NUM_SW-1:0] : '0)) | edge_set;
        irq_d      = |(edge_q & irq_mask_q);
    end

    // Read mux, registered to give a fixed one-cycle read latency.
    always_comb begin
        rdata_d = '0;
        if (avs_read) begin
            case (avs_address)
                AddrCtrl:     rdata_d = {28'd0, ctrl_q};
                AddrPattern:  rdata_d = 32'(pattern_q);
                AddrPeriod:   rdata_d = period_q;
                AddrSwStatus: rdata_d = 32'(sw_stable_q);
                AddrIrqMask:  rdata_d = 32'(irq_mask_q);
                AddrEdge:     rdata_d = 32'(edge_q);
                default:      rdata_d = '0;
            endcase
        end
    end

    // Sequencer next state and registered LED value computed from the next-state view.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        shift_d = shift_q;
        phase_d = phase_q;
        led_d   = '0;
        unique case (state_q)
            StIdle: begin
                step_d  = '0;
                shift_d = pattern_d;
                phase_d = 1'b0;
                if (ctrl_q[0]) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!ctrl_q[0]) begin
                    state_d = StIdle;
                    step_d  = '0;
                    shift_d = pattern_d;
                    phase_d = 1'b0;
                end else if (restart) begin
                    step_d  = '0;
                    shift_d = pattern_d;
                    phase_d = 1'b0;
                end else if (tick) begin
                    step_d  = '0;
                    shift_d = {shift_q[NUM_LEDS-2:0], shift_q[NUM_LEDS-1]};
                    phase_d = ~phase_q;
                end else begin
                    step_d = step_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StRun) begin
            unique case (eff_mode)
                ModeDirect: led_d = pattern_d;
                ModeBlink:  led_d = phase_d ? '0 : pattern_d;
                ModeChase:  led_d = shift_d;
                ModeMirror: led_d = sw_led;
            endcase
        end
    end

    // State registers, all cleared asynchronously; PERIOD resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            sw_stable_q <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                db_cnt_q[i] <= '0;
            end
            ctrl_q      <= '0;
            pattern_q   <= '0;
            period_q    <= 32'd1;
            irq_mask_q  <= '0;
            edge_q      <= '0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
            state_q     <= StIdle;
            step_q      <= '0;
            shift_q     <= '0;
            phase_q     <= 1'b0;
            mode_q      <= '0;
            led_q       <= '0;
        end else begin
            sw_meta_q   <= sw_in;
            sw_sync_q   <= sw_meta_q;
            sw_stable_q <= sw_stable_d;
            db_cnt_q    <= db_cnt_d;
            ctrl_q      <= ctrl_d;
            pattern_q   <= pattern_d;
            period_q    <= period_d;
            irq_mask_q  <= irq_mask_d;
            edge_q      <= edge_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
            state_q     <= state_d;
            step_q      <= step_d;
            shift_q     <= shift_d;
            phase_q     <= phase_d;
            mode_q      <= eff_mode;
            led_q       <= led_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign led_out      = led_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_led_sw_sequencer.sv
// Bench for led_sw_sequencer: directed steps plus randomized patterns, periods and
// switch activity, checked against a cycle-count model of the LED and switch behaviour.
module tb_led_sw_sequencer;

    localparam int NL = 8;
    localparam int NS = 4;
    localparam int DB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [31:0]   avs_readdata;
    logic [NS-1:0] sw_in;
    logic [NL-1:0] led_out;
    logic          irq;

    int total = 0;
    int bad   = 0;

    led_sw_sequencer #(
        .NUM_LEDS        (NL),
        .NUM_SW          (NS),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .sw_in         (sw_in),
        .led_out       (led_out),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick1();
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        tick1();
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    // Model: LED value n clocks after the sequence (re)started.
    function automatic logic [7:0] rotl(input logic [7:0] p, input int k);
        int          s;
        logic [15:0] w;
        s = k % 8;
        w = {8'h00, p} << s;
        return w[7:0] | w[15:8];
    endfunction

    function automatic logic [7:0] chase_exp(input logic [7:0] p, input int per, input int n);
        return rotl(p, n / per);
    endfunction

    function automatic logic [7:0] blink_exp(input logic [7:0] p, input int per, input int n);
        return ((n / per) % 2 == 1) ? 8'h00 : p;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rv;
        logic [31:0] exp_rst [8];
        logic [3:0]  sw_model;
        logic [3:0]  edge_model;
        logic [3:0]  v;
        logic [7:0]  pat;
        int          per;
        int          mode;
        int          g;
        bit          found;

        reset         = 1'b1;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        sw_in         = '0;
        repeat (3) tick1();
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
        reset = 1'b0;

        // Reset values of the whole map.
        exp_rst = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), rv);
            chk($sformatf("rst_reg%0d", a), rv, exp_rst[a]);
        end

        // Short glitch is rejected, long level is accepted.
        sw_in = 4'b0100;
        repeat (10) tick1();
        sw_in = 4'b0000;
        repeat (30) tick1();
        rd(3'd3, rv);
        chk("glitch_sw", rv, 32'h0);
        rd(3'd5, rv);
        chk("glitch_edge", rv, 32'h0);
        sw_in = 4'b0100;
        repeat (40) tick1();
        rd(3'd3, rv);
        chk("db_sw", rv, 32'h4);
        rd(3'd5, rv);
        chk("db_edge", rv, 32'h4);
        chk("irq_unmasked", 32'(irq), 32'h0);
        wr(3'd4, 32'h4);
        chk("irq_mask_lag", 32'(irq), 32'h0);
        tick1();
        chk("irq_rise", 32'(irq), 32'h1);
        wr(3'd5, 32'h4);
        chk("irq_clr_lag", 32'(irq), 32'h1);
        tick1();
        chk("irq_fall", 32'(irq), 32'h0);

        // Random glitches and accepted levels against a switch/edge model.
        sw_model   = 4'b0100;
        edge_model = 4'b0000;
        for (int it = 0; it < 5; it++) begin
            v     = 4'($urandom_range(0, 15));
            g     = $urandom_range(1, DB - 1);
            sw_in = v;
            repeat (g) tick1();
            sw_in = sw_model;
            repeat (25) tick1();
            rd(3'd3, rv);
            chk("rnd_glitch_sw", rv, 32'(sw_model));
            sw_in = v;
            repeat (30) tick1();
            edge_model = edge_model | (sw_model ^ v);
            sw_model   = v;
            rd(3'd3, rv);
            chk("rnd_sw", rv, 32'(sw_model));
            rd(3'd5, rv);
            chk("rnd_edge", rv, 32'(edge_model));
            chk("rnd_irq", 32'(irq), 32'(edge_model[2]));
        end
        wr(3'd5, 32'hF);

        // Chase 0x81 with period 4, through the MSB wrap.
        wr(3'd1, 32'h81);
        wr(3'd2, 32'd4);
        wr(3'd0, 32'h5);
        for (int n = 0; n < 36; n++) begin
            tick1();
            chk($sformatf("chase_n%0d", n), 32'(led_out), 32'(chase_exp(8'h81, 4, n)));
        end
        wr(3'd0, 32'h0);
        chk("chase_before_off", 32'(led_out), 32'(chase_exp(8'h81, 4, 36)));
        tick1();
        chk("chase_off", 32'(led_out), 32'h0);

        // Blink 0xA5 period 3, then PERIOD=0 restarts at period 1.
        wr(3'd1, 32'hA5);
        wr(3'd2, 32'd3);
        wr(3'd0, 32'h3);
        for (int n = 0; n < 15; n++) begin
            tick1();
            chk($sformatf("blink_n%0d", n), 32'(led_out), 32'(blink_exp(8'hA5, 3, n)));
        end
        wr(3'd2, 32'd0);
        chk("blink_p1_n0", 32'(led_out), 32'hA5);
        for (int n = 1; n < 6; n++) begin
            tick1();
            chk($sformatf("blink_p1_n%0d", n), 32'(led_out), 32'(blink_exp(8'hA5, 1, n)));
        end
        rd(3'd2, rv);
        chk("period_zero_read", rv, 32'd1);

        // Randomized chase/blink runs.
        wr(3'd0, 32'h0);
        for (int it = 0; it < 4; it++) begin
            pat  = 8'($urandom_range(1, 255));
            per  = $urandom_range(1, 5);
            mode = $urandom_range(1, 2);
            wr(3'd1, 32'(pat));
            wr(3'd2, 32'(per));
            wr(3'd0, 32'(1 | (mode << 1)));
            for (int n = 0; n < 3 * per + 4; n++) begin
                tick1();
                if (mode == 2) begin
                    chk("rnd_chase", 32'(led_out), 32'(chase_exp(pat, per, n)));
                end else begin
                    chk("rnd_blink", 32'(led_out), 32'(blink_exp(pat, per, n)));
                end
            end
            wr(3'd0, 32'h0);
            tick1();
            chk("rnd_off", 32'(led_out), 32'h0);
        end

        // Switch-selected mode: mirror with sw=1011, then sw=1010 restarts as chase.
        sw_in = 4'b1011;
        repeat (30) tick1();
        rd(3'd3, rv);
        chk("mirror_sw", rv, 32'hB);
        wr(3'd1, 32'hA5);
        wr(3'd2, 32'd4);
        wr(3'd0, 32'h9);
        for (int n = 0; n < 3; n++) begin
            tick1();
            chk("mirror_led", 32'(led_out), 32'h0B);
        end
        sw_in = 4'b1010;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick1();
            if (led_out === 8'hA5) begin
                found = 1'b1;
            end else begin
                chk("mirror_hold", 32'(led_out), 32'h0B);
            end
        end
        chk("swsel_restart_seen", 32'(found), 32'h1);
        for (int n = 1; n < 10; n++) begin
            tick1();
            chk("swsel_chase", 32'(led_out), 32'(chase_exp(8'hA5, 4, n)));
        end

        // Asynchronous reset mid-run.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_led", 32'(led_out), 32'h0);
        chk("async_rst_irq", 32'(irq), 32'h0);
        chk("async_rst_rdata", avs_readdata, 32'h0);
        repeat (2) tick1();
        reset = 1'b0;
        rd(3'd2, rv);
        chk("post_rst_period", rv, 32'd1);
        rd(3'd0, rv);
        chk("post_rst_ctrl", rv, 32'd0);
        rd(3'd3, rv);
        chk("post_rst_sw", rv, 32'd0);
        chk("post_rst_led", 32'(led_out), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
